// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_pkg
// Description : Shared constants and types for the VGA frame-buffer arbiter.
//               Holds the default display timing, the derived frame-buffer
//               geometry, the fetch look-ahead and the controller state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_fb_pkg;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_TOTAL_DEF     = 800;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int V_TOTAL_DEF     = 525;
    localparam int SCALE_SHIFT_DEF = 2;

    // One frame-buffer word covers a 4x4 block of screen pixels.
    localparam int FB_COLS  = H_ACTIVE_DEF >> SCALE_SHIFT_DEF;   // 160
    localparam int FB_ROWS  = V_ACTIVE_DEF >> SCALE_SHIFT_DEF;   // 120
    localparam int FB_WORDS = FB_COLS * FB_ROWS;                 // 19200

    // Fetch runs this many clocks ahead of the beam: 1 cycle to register the
    // address, 1 cycle RAM latency, 1 cycle into the pixel register.
    localparam int PREFETCH = 3;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fetch_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_fetch_addr_gen
// Description : Combinational fetch-target generator. Looks PREFETCH clocks
//               ahead of the current H/V count (wrapping into the next line
//               and frame), flags display slots and forms the word address.
// Ports       : i_h, i_v      - current horizontal / vertical count
//               o_slot        - this cycle belongs to display scan-out
//               o_addr        - frame-buffer word address of the target
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fetch_addr_gen
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic [15:0]       i_h,
    input  logic [15:0]       i_v,
    output logic              o_slot,
    output logic [ADDR_W-1:0] o_addr
);

    // 17-bit arithmetic so that H+3 / V+1 cannot overflow on any 16-bit input.
    localparam logic [16:0] C_H_ACTIVE = 17'(H_ACTIVE);
    localparam logic [16:0] C_H_TOTAL  = 17'(H_TOTAL);
    localparam logic [16:0] C_V_ACTIVE = 17'(V_ACTIVE);
    localparam logic [16:0] C_V_TOTAL  = 17'(V_TOTAL);
    localparam logic [16:0] C_PREFETCH = 17'(PREFETCH);
    localparam logic [16:0] C_H_WRAP   = 17'(H_TOTAL - PREFETCH);
    localparam logic [16:0] C_MASK     = 17'((1 << SCALE_SHIFT) - 1);

    logic [16:0] w_h;
    logic [16:0] w_v;
    logic [16:0] w_v_next;
    logic [16:0] w_tx;
    logic [16:0] w_ty;
    logic [16:0] w_col;
    logic [16:0] w_row;
    logic        w_wrap;
    logic        w_in_range;

    always_comb begin
        w_h        = {1'b0, i_h};
        w_v        = {1'b0, i_v};
        w_in_range = (w_h < C_H_TOTAL) && (w_v < C_V_TOTAL);
        w_wrap     = (w_h >= C_H_WRAP);
        w_v_next   = w_v + 17'd1;

        // Near the line end the target falls on the start of the next line.
        if (w_wrap) begin
            w_tx = w_h + C_PREFETCH - C_H_TOTAL;
            w_ty = (w_v_next >= C_V_TOTAL) ? 17'd0 : w_v_next;
        end else begin
            w_tx = w_h + C_PREFETCH;
            w_ty = w_v;
        end

        o_slot = w_in_range && (w_tx < C_H_ACTIVE) && (w_ty < C_V_ACTIVE) &&
                 ((w_tx & C_MASK) == 17'd0);

        w_col  = w_tx >> SCALE_SHIFT;
        w_row  = w_ty >> SCALE_SHIFT;
        // row * 160 as row*128 + row*32 (FB_COLS = 160).
        o_addr = (ADDR_W'(w_row) << 7) + (ADDR_W'(w_row) << 5) + ADDR_W'(w_col);
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Single-port frame-RAM arbiter for the VGA path. Display
//               scan-out owns fixed slots (1 in 4 clocks on active lines);
//               every other slot goes to the power-up clear engine or to the
//               drawing client via a req/ack handshake. Also holds the pixel
//               register feeding the DAC.
// Config      : FB_CLEAR_EN - when defined, reset starts a clear of the whole
//               frame buffer to CLEAR_VALUE before the client is served.
// Ports       : clk_25MHz, rst (async, active-high)
//               H_Count_Value, V_Count_Value - beam position
//               wr_req/wr_addr/wr_data/wr_ack - client write handshake
//               mem_addr/mem_we/mem_wdata/mem_rdata - frame RAM port
//               pixel_out - pixel for current position, 0 when blanked
//               clear_busy - power-up clear in progress
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int SCALE_SHIFT = 2,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 15,
    parameter int CLEAR_VALUE = 0
) (
    input  logic              clk_25MHz,
    input  logic              rst,
    input  logic [15:0]       H_Count_Value,
    input  logic [15:0]       V_Count_Value,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_out,
    output logic              clear_busy
);

    localparam int                C_WORDS    = (H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] C_FB_WORDS = ADDR_W'(C_WORDS);
    localparam logic [15:0]       C_H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0]       C_V_ACT    = 16'(V_ACTIVE);

    fb_state_t         r_state;
    fb_state_t         w_state_nxt;
    logic              w_slot;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_grant_clr;
    logic              w_grant_wr;
    logic              r_wr_ack;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_v1;
    logic              r_rd_v2;
    logic [DATA_W-1:0] r_pix;

    vga_fetch_addr_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_TOTAL     (H_TOTAL),
        .V_ACTIVE    (V_ACTIVE),
        .V_TOTAL     (V_TOTAL),
        .SCALE_SHIFT (SCALE_SHIFT),
        .ADDR_W      (ADDR_W)
    ) u_fetch (
        .i_h    (H_Count_Value),
        .i_v    (V_Count_Value),
        .o_slot (w_slot),
        .o_addr (w_disp_addr)
    );

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] C_CLR_LAST = C_FB_WORDS - ADDR_W'(1);

    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_clear_busy;

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            r_clr_addr   <= '0;
            r_clear_busy <= 1'b1;
        end else begin
            if (w_grant_clr) begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
            // Lags the state by one cycle so the flag still covers the final
            // clear write while it is on the RAM port.
            r_clear_busy <= (r_state == CLEAR);
        end
    end

    assign clear_busy = r_clear_busy;
`else
    assign clear_busy = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
`ifdef FB_CLEAR_EN
            r_state <= CLEAR;
`else
            r_state <= RUN;
`endif
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot allocation and next state. Display slots always win.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_clr = 1'b0;
        w_grant_wr  = 1'b0;
        if (!w_slot) begin
`ifdef FB_CLEAR_EN
            if (r_state == CLEAR) begin
                w_grant_clr = 1'b1;
                if (r_clr_addr == C_CLR_LAST) begin
                    w_state_nxt = RUN;
                end
            end else
`endif
            // Gating on r_wr_ack stops a still-held request from being
            // granted twice in the ack cycle.
            if ((r_state == RUN) && wr_req && !r_wr_ack) begin
                w_grant_wr = 1'b1;
            end
        end
    end

    // RAM port, ack and pixel pipeline
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_wr_ack    <= 1'b0;
            r_rd_v1     <= 1'b0;
            r_rd_v2     <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_wr_ack <= w_grant_wr;
            r_rd_v1  <= w_slot;
            r_rd_v2  <= r_rd_v1;
            if (r_rd_v2) begin
                r_pix <= mem_rdata;
            end

            if (w_slot) begin
                r_mem_addr <= w_disp_addr;
                r_mem_we   <= 1'b0;
            end else if (w_grant_clr) begin
`ifdef FB_CLEAR_EN
                r_mem_addr <= r_clr_addr;
`endif
                r_mem_we    <= 1'b1;
                r_mem_wdata <= DATA_W'(CLEAR_VALUE);
            end else if (w_grant_wr) begin
                // Out-of-range writes are acknowledged but never reach RAM.
                r_mem_addr  <= wr_addr;
                r_mem_we    <= (wr_addr < C_FB_WORDS);
                r_mem_wdata <= wr_data;
            end else begin
                r_mem_we <= 1'b0;
            end
        end
    end

    assign wr_ack    = r_wr_ack;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign pixel_out = ((H_Count_Value < C_H_ACT) && (V_Count_Value < C_V_ACT)) ? r_pix : '0;

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Frame-buffer access controller for the VGA path. It shares one single-port synchronous frame RAM between two users: display scan-out, which has fixed, absolute-priority slots derived from the horizontal/vertical count values, and one drawing client, which gets every remaining slot through a req/ack handshake. The block sits between the H/V counters, the frame RAM and the colour output stage. It also holds the pixel register that feeds the DAC.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- SCALE_SHIFT, 2, each frame-buffer word covers 4×4 screen pixels
- DATA_W, 8, pixel word width
- ADDR_W, 15, RAM address width
- CLEAR_VALUE, 0, word written by the power-up clear

Ports:
- clk_25MHz  in  1  pixel clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-high
- H_Count_Value  in  16  current horizontal count
- V_Count_Value  in  16  current vertical count
- wr_req  in  1  client write request; held until wr_ack
- wr_addr  in  ADDR_W  client word address; stable while wr_req is high
- wr_data  in  DATA_W  client data; stable while wr_req is high
- wr_ack  out  1  one-cycle pulse: write issued, or dropped if out of range
- mem_addr  out  ADDR_W  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_addr
- pixel_out  out  DATA_W  pixel for the current H/V count; 0 outside the active area
- clear_busy  out  1  power-up clear in progress

## Operation
- **Fetch target.** Computed each cycle:
  - tx = (H + 3) mod H_TOTAL.
  - ty = V, except when H ≥ H_TOTAL−3, where ty = (V + 1) mod V_TOTAL.
- **Display slot.** A cycle is a display slot when tx < H_ACTIVE, ty < V_ACTIVE and tx[1:0] == 0. Count inputs ≥ H_TOTAL or ≥ V_TOTAL never produce a slot.
- **Display address.** (ty>>2)*160 + (tx>>2), range 0..19199, computed at 15 bits with no overflow. Use shift-add: row<<7 + row<<5 + col.
- **Slot priority.**
  - A display slot always issues a read (mem_we = 0).
  - A free slot (not a display slot) goes to the clear engine or the writer.
  - The writer is granted only when wr_req = 1, wr_ack is currently 0 and the state is RUN.
- **Out-of-range writes.** A write with wr_addr ≥ 19200 is acknowledged with mem_we held at 0 (dropped).
- **Pixel register.** Loads mem_rdata two cycles after the display decision. It holds that value for 4 clocks.
- **pixel_out.** Equals the pixel register when H < H_ACTIVE and V < V_ACTIVE, otherwise 0. This output is combinational from the inputs.
- **States.** CLEAR and RUN.
  - CLEAR: a clear counter writes CLEAR_VALUE to addresses 0..19199, one per free slot. After 19199 is written, the state goes to RUN.
  - During CLEAR, display reads continue and the writer is never acked.
  - RUN is permanent until reset.
- **Reset.** Asserting rst at any time, including mid-clear or mid-handshake, restarts the clear from address 0 (if enabled) and drops any pending grant.

## Timing
- **Decision pipeline.** A decision made in cycle t appears on mem_* in cycle t+1. mem_rdata is valid in t+2 and is latched at the end of t+2. pixel_out is valid at t+3, when H equals the target tx.
- **Write handshake.** wr_ack goes high in t+1, the same cycle mem_we is high. The client may change wr_addr/wr_data or drop wr_req from t+2. Sustained throughput is at most one write per 2 cycles.
- **Active lines.** Display uses 1 of every 4 cycles, so a pending write waits at most 1 extra cycle.
- **Values while rst is high and after release:**
  - mem_addr, mem_wdata, pixel register: 0
  - mem_we, wr_ack: 0
  - clear_busy: 1 with FB_CLEAR_EN, 0 without
  - pixel_out: 0 until the first fetched pixel is latched

## Configuration
- **FB_CLEAR_EN defined:** reset enters CLEAR. clear_busy is high until the last clear write appears on mem_* (inclusive).
- **FB_CLEAR_EN undefined:** reset enters RUN directly. clear_busy is tied 0 and no clear counter is built.

## Structure
- **Package vga_fb_pkg** holds:
  - timing constants, and the derived FB_COLS = 160, FB_ROWS = 120, FB_WORDS = 19200
  - the PREFETCH = 3 constant
  - the state enum {CLEAR, RUN}
- **Sub-module vga_fetch_addr_gen:** pure combinational. Maps H/V to tx, ty, the display-slot flag and the display address.

## Test plan
- **Line-end fetch.** V = 0, H = 633 → mem_addr = 159 and mem_we = 0 next cycle. H = 637 → no display slot.
- **Line wrap.** V = 3, H = 797 → fetch address 160 (row 1). V = 524, H = 797 → address 0.
- **Pixel timing.** RAM word 0 = 0xA5, V = 0, H sweeps 797..4 → pixel_out = 0xA5 for H = 0..3 and 0 at H = 799.
- **Collision.** wr_req with wr_addr = 5, wr_data = 0x3C, arriving in the cycle with H = 1 (a display slot) → no grant that cycle. Grant at H = 2, then mem_we = 1, mem_addr = 5, mem_wdata = 0x3C and wr_ack = 1 at H = 3.
- **Out-of-range write.** wr_addr = 19200 → wr_ack pulses, mem_we stays 0.
- **Clear (FB_CLEAR_EN).** clear_busy stays 1 and writer requests are unacked until 19200 clear writes of 0 are observed. rst pulsed mid-clear → the next clear write targets address 0.
